// File: rtl/pipelined_xor_accumulator.sv
// Pipelined wide XOR with optional per-frame syndrome folding for the decoder datapath.
// Results carry parity, zero flag and beat count through a STAGES-deep valid/ready pipeline.
module pipelined_xor_accumulator #(
    parameter int WIDTH  = 17,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count,
    output logic             acc_open
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic parity_f(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    logic             en_s;
    logic             accept_s;
    logic [WIDTH-1:0] x_s;
    logic [CNT_W-1:0] cnt_inc_s;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             open_q, open_d;

    logic             s1_vld_d;
    logic [WIDTH-1:0] s1_data_d;
    logic [CNT_W-1:0] s1_cnt_d;
    logic             s1_par_d;
    logic             s1_zero_d;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] par_q;
    logic [STAGES-1:0] zero_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [CNT_W-1:0]  pcnt_q [STAGES];

    // The whole pipeline, accumulator included, advances only when the output slot can move.
    assign en_s      = ~vld_q[STAGES-1] | out_ready;
    assign accept_s  = in_valid & en_s;
    assign x_s       = in_a ^ in_b;
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);

    // Stage-1 result selection and accumulator next state.
    always_comb begin
        s1_vld_d  = 1'b0;
        s1_data_d = '0;
        s1_cnt_d  = '0;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        open_d    = open_q;
        if (accept_s) begin
            if (!in_mode) begin
                s1_vld_d  = 1'b1;
                s1_data_d = x_s;
                s1_cnt_d  = CNT_ONE;
            end else if (!in_last) begin
                acc_d  = acc_q ^ x_s;
                cnt_d  = cnt_inc_s;
                open_d = 1'b1;
            end else begin
                s1_vld_d  = 1'b1;
                s1_data_d = acc_q ^ x_s;
                s1_cnt_d  = cnt_inc_s;
                acc_d     = '0;
                cnt_d     = '0;
                open_d    = 1'b0;
            end
        end else begin
            s1_vld_d = 1'b0;
        end
        s1_par_d  = parity_f(s1_data_d);
        s1_zero_d = s1_vld_d & ~(|s1_data_d);
    end

    // Accumulator, frame state and delay pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            open_q <= 1'b0;
            vld_q  <= '0;
            par_q  <= '0;
            zero_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
                pcnt_q[i] <= '0;
            end
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            open_q <= open_d;
            if (en_s) begin
                vld_q[0]  <= s1_vld_d;
                par_q[0]  <= s1_par_d;
                zero_q[0] <= s1_zero_d;
                data_q[0] <= s1_data_d;
                pcnt_q[0] <= s1_cnt_d;
                for (int i = 1; i < STAGES; i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    par_q[i]  <= par_q[i-1];
                    zero_q[i] <= zero_q[i-1];
                    data_q[i] <= data_q[i-1];
                    pcnt_q[i] <= pcnt_q[i-1];
                end
            end
        end
    end

    assign in_ready   = en_s;
    assign out_valid  = vld_q[STAGES-1];
    assign out_data   = data_q[STAGES-1];
    assign out_count  = pcnt_q[STAGES-1];
    assign out_parity = par_q[STAGES-1];
    assign out_zero   = zero_q[STAGES-1];
    assign acc_open   = open_q;

endmodule

// File: tb/tb_pipelined_xor_accumulator.sv
// Self-checking bench for pipelined_xor_accumulator: vector table, corner sequences and
// randomized traffic against a frame-level reference model.
module tb_pipelined_xor_accumulator;

    localparam int WIDTH  = 17;
    localparam int STAGES = 2;
    localparam int CNT_W  = 8;
    localparam int CNT_SAT = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_mode = 1'b0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;
    logic             out_zero;
    logic [CNT_W-1:0] out_count;
    logic             acc_open;

    pipelined_xor_accumulator #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_parity(out_parity), .out_zero(out_zero),
        .out_count(out_count), .acc_open(acc_open)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             mode;
        logic             last;
        logic [WIDTH-1:0] exp_data;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_par;
        logic             exp_zero;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               c;
    } res_t;

    vec_t tbl [5];
    res_t exp_q [$];
    res_t got_q [$];

    int n_pass = 0;
    int n_total = 0;

    // reference model state: frame-level fold
    logic [WIDTH-1:0] m_acc = '0;
    int               m_cnt = 0;
    logic             m_open = 1'b0;

    logic             s_ov, s_ir, s_par, s_zero, s_acc;
    logic [WIDTH-1:0] s_data;
    logic [CNT_W-1:0] s_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_acc  = '0;
        m_cnt  = 0;
        m_open = 1'b0;
    endtask

    // One clock: drive at negedge, sample shortly after, score handshakes, update model.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic mode, input logic last, input logic ordy);
        res_t e;
        res_t g;
        logic [WIDTH-1:0] x;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_mode   = mode;
        in_last   = last;
        out_ready = ordy;
        #1;
        s_ov = out_valid; s_ir = in_ready; s_data = out_data; s_cnt = out_count;
        s_par = out_parity; s_zero = out_zero;
        s_acc = v & in_ready;
        chk("acc_open", acc_open, m_open);
        chk("in_ready_rule", in_ready, (!out_valid || ordy));
        if (out_valid && ordy) begin
            chk("out_expected", exp_q.size() != 0, 1);
            g.d = out_data;
            g.c = out_count;
            got_q.push_back(g);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("model_data", out_data, e.d);
                chk("model_count", out_count, e.c);
                chk("model_parity", out_parity, ($countones(e.d) % 2) == 1);
                chk("model_zero", out_zero, e.d == '0);
            end
        end
        if (s_acc) begin
            x = a ^ b;
            if (!mode) begin
                e.d = x; e.c = 1;
                exp_q.push_back(e);
            end else begin
                m_acc = m_acc ^ x;
                m_cnt = (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;
                if (last) begin
                    e.d = m_acc; e.c = m_cnt;
                    exp_q.push_back(e);
                    m_acc = '0; m_cnt = 0; m_open = 1'b0;
                end else begin
                    m_open = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy);
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            idle(1'b1);
            if (exp_q.size() == 0 && !s_ov) break;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int               lat;
        logic             seen;
        logic [WIDTH-1:0] held_d;
        logic [CNT_W-1:0] held_c;
        logic [WIDTH-1:0] bp [4];
        int               idx;

        tbl[0] = '{17'h1FFFF, 17'h0F0F0, 1'b0, 1'b0, 17'h10F0F, 8'd1, 1'b1, 1'b0};
        tbl[1] = '{17'h12345, 17'h12345, 1'b0, 1'b0, 17'h00000, 8'd1, 1'b0, 1'b1};
        tbl[2] = '{17'h00005, 17'h00000, 1'b1, 1'b1, 17'h00005, 8'd1, 1'b0, 1'b0};
        tbl[3] = '{17'h0AAAA, 17'h05555, 1'b0, 1'b1, 17'h0FFFF, 8'd1, 1'b0, 1'b0};
        tbl[4] = '{17'h10000, 17'h00001, 1'b0, 1'b0, 17'h10001, 8'd1, 1'b0, 1'b0};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc_open", acc_open, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_zero", out_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // vector table: single result-producing beats, latency and flags
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].last, 1'b1);
            seen = 1'b0;
            lat  = 0;
            for (int k = 1; k <= 10 && !seen; k++) begin
                idle(1'b1);
                if (s_ov) begin
                    seen = 1'b1;
                    lat  = k;
                    chk($sformatf("tbl%0d_data", i), s_data, tbl[i].exp_data);
                    chk($sformatf("tbl%0d_count", i), s_cnt, tbl[i].exp_cnt);
                    chk($sformatf("tbl%0d_parity", i), s_par, tbl[i].exp_par);
                    chk($sformatf("tbl%0d_zero", i), s_zero, tbl[i].exp_zero);
                end
            end
            chk($sformatf("tbl%0d_latency", i), lat, STAGES);
        end
        drain();

        // three-beat accumulate frame
        got_q.delete();
        cycle(1'b1, 17'h00001, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 17'h00003, '0, 1'b1, 1'b0, 1'b1);
        chk("frame_open_after_b1", acc_open, 1);
        cycle(1'b1, 17'h00004, '0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        chk("frame_open_after_b3", acc_open, 0);
        drain();
        chk("frame_n_out", got_q.size(), 1);
        if (got_q.size() == 1) begin
            chk("frame_data", got_q[0].d, 17'h00006);
            chk("frame_count", got_q[0].c, 3);
        end

        // pass beat interleaved inside an open frame
        got_q.delete();
        cycle(1'b1, 17'h00010, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 17'h00001, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 17'h00020, '0, 1'b1, 1'b1, 1'b1);
        drain();
        chk("ilv_n_out", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("ilv_first_data", got_q[0].d, 17'h00001);
            chk("ilv_first_count", got_q[0].c, 1);
            chk("ilv_second_data", got_q[1].d, 17'h00030);
            chk("ilv_second_count", got_q[1].c, 2);
        end

        // backpressure: out_ready low for 3 cycles from the first out_valid
        got_q.delete();
        for (int i = 0; i < 4; i++) bp[i] = WIDTH'($urandom);
        idx = 0;
        held_d = '0;
        held_c = '0;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            cycle(1'b1, bp[idx], '0, 1'b0, 1'b0, !(k >= 2 && k < 5));
            if (k >= 2 && k < 5) begin
                chk("bp_stall_in_ready", s_ir, 0);
                chk("bp_stall_valid", s_ov, 1);
            end
            if (k == 2) begin
                held_d = s_data;
                held_c = s_cnt;
            end
            if (k == 3 || k == 4) begin
                chk("bp_hold_data", s_data, held_d);
                chk("bp_hold_count", s_cnt, held_c);
            end
            if (s_acc) idx++;
        end
        chk("bp_all_accepted", idx, 4);
        drain();
        chk("bp_n_out", got_q.size(), 4);
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("bp_order%0d", i), got_q[i].d, bp[i]);
        end

        // counter saturation on a long frame
        got_q.delete();
        for (int i = 0; i < 299; i++) cycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b1, 1'b0, 1'b1);
        cycle(1'b1, WIDTH'($urandom), '0, 1'b1, 1'b1, 1'b1);
        drain();
        chk("sat_n_out", got_q.size(), 1);
        if (got_q.size() == 1) chk("sat_count", got_q[0].c, CNT_SAT);

        // randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end
        cycle(1'b1, '0, '0, 1'b1, 1'b1, 1'b1);
        drain();

        // asynchronous reset with a frame open and a result held at the output
        cycle(1'b1, 17'h00007, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 17'h00009, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 17'h0001F, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        chk("pre_rst_valid", s_ov, 1);
        chk("pre_rst_open", acc_open, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_open", acc_open, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_count", out_count, 0);
        chk("mid_rst_parity", out_parity, 0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        got_q.delete();
        cycle(1'b1, 17'h00005, '0, 1'b1, 1'b1, 1'b1);
        drain();
        chk("post_rst_n_out", got_q.size(), 1);
        if (got_q.size() == 1) begin
            chk("post_rst_data", got_q[0].d, 17'h00005);
            chk("post_rst_count", got_q[0].c, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipelined_xor_accumulator.md
Name: pipelined_xor_accumulator

Overview:
- Parametrised, pipelined successor to the team's combinational 17-bit wide-XOR gate, for the decoder datapath.
- Computes the bitwise XOR of two WIDTH-bit vectors per beat. Supports two modes:
  - pass mode: each beat produces one result.
  - accumulate mode: beats are XOR-folded across a frame, and one syndrome is emitted per frame.
- Results travel through a STAGES-deep register pipeline with valid/ready flow control.
- Each result carries a parity bit, a zero-syndrome flag and a beat count. These feed the downstream error-locator/correction stage.

Parameters:
- WIDTH, 17, bit width of operands and result.
- STAGES, 2, total register stages from input acceptance to output; legal 1..4.
- CNT_W, 8, width of the per-frame beat counter (saturating).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_mode  input  1  0 = pass, 1 = accumulate.
- in_last  input  1  closes an accumulate frame; ignored in pass mode.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  XOR result or accumulated syndrome.
- out_parity  output  1  reduction XOR of out_data.
- out_zero  output  1  1 when out_data == 0.
- out_count  output  CNT_W  beats folded into the result; 1 in pass mode.
- acc_open  output  1  an accumulate frame is in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Every pipeline valid bit, accumulator, beat counter, out_* and acc_open go to 0 immediately.
  - in_ready is 1 once rst_n deasserts.
  - A frame open at reset is discarded; no partial result is emitted.
- Flow control:
  - Global enable en = !out_valid | out_ready. in_ready = en.
  - A beat is accepted when in_valid & in_ready.
  - When en = 0, all stages hold, including the accumulator and counter.
  - out_data/out_parity/out_zero/out_count stay stable while out_valid & !out_ready.
- Stage 1 (accept), x = in_a ^ in_b:
  - Pass beat (mode 0): stage-1 result = x, count = 1, valid = 1. The accumulator is untouched, so a pass beat may interleave inside an open frame.
  - Accumulate beat, in_last = 0: acc <= acc ^ x; cnt <= sat(cnt + 1); acc_open <= 1; stage-1 valid = 0 (beat absorbed).
  - Accumulate beat, in_last = 1: stage-1 result = acc ^ x, count = sat(cnt + 1), valid = 1. Then acc <= 0, cnt <= 0, acc_open <= 0.
  - A single-beat frame (first beat has in_last = 1) emits x with count = 1.
  - No accepted beat: stage-1 valid = 0 and the accumulator holds.
- Counter saturates at 2^CNT_W − 1 and never wraps. The accumulator keeps folding beyond saturation.
- Stages 2..STAGES are pure delay registers (data, count, valid) advancing on en.
- out_parity and out_zero are derived from the final-stage data (combinational from the last register is acceptable). They are meaningful only when out_valid = 1.
- Latency with no backpressure: a result-producing beat accepted at cycle t gives out_valid at t + STAGES.
- Throughput: one beat per cycle sustained while out_ready = 1.
- Bubbles are not collapsed: absorbed beats leave empty slots that propagate.
- Simultaneous accept and output handshake in the same cycle is legal and loses no data.

Test Plan:
- Pass mode, STAGES=2, out_ready=1: a=17'h1FFFF, b=17'h0F0F0 at cycle 0 -> cycle 2: out_data=17'h10F0F, out_parity=1, out_zero=0, out_count=1.
- Accumulate frame of 3 beats, (a,b) = (17'h00001,0), (17'h00003,0), (17'h00004,0) with last on beat 3 -> exactly one out_valid, out_data=17'h00006, out_count=3, acc_open high after beat 1 and low after beat 3.
- Zero syndrome: a=b=17'h12345 in pass mode -> out_data=0, out_zero=1, out_parity=0.
- Backpressure: stream 4 pass beats with out_ready held 0 for 3 cycles from the first out_valid -> in_ready=0 during the stall, output held stable, all 4 results delivered in order with no loss or duplication.
- Interleave: open frame (beat 17'h00010), pass beat 17'h00001^0, then closing beat 17'h00020 -> outputs in order 17'h00001 (count 1), then 17'h00030 (count 2).
- Reset mid-frame: assert rst_n low after 2 accumulate beats -> all outputs 0 immediately; after release, a new 1-beat frame of 17'h00005 emits 17'h00005 with count 1.
